// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave arbiter for the mips_cpu_bus memory interface.
// Master 0 is the data port, master 1 is instruction fetch. One transaction is
// owned at a time. Each transaction returns exactly one completion, signalled
// by dropping the owner's waitrequest for a single cycle.
//
// Parameters:
//   READ_LATENCY - cycles from slave read acceptance to valid s_readdata (1..15)
// Optional build macro:
//   ARB_ROUND_ROBIN_EN - on a tie the master that did not complete last wins;
//                        when undefined m0 always beats m1.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   mN_address_i/read_i/write_i          master N request
//   mN_writedata_i/byteenable_i          master N write payload
//   mN_waitrequest_o/readdata_o          master N stall and read data
//   s_address_o/read_o/write_o           slave request
//   s_writedata_o/byteenable_o           slave write payload
//   s_waitrequest_i/readdata_i           slave stall and read data
//   grant_o                              one-hot owner {m1,m0}, 00 when idle
module mips_bus_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] m0_address_i,
  input  logic        m0_read_i,
  input  logic        m0_write_i,
  input  logic [31:0] m0_writedata_i,
  input  logic [3:0]  m0_byteenable_i,
  output logic        m0_waitrequest_o,
  output logic [31:0] m0_readdata_o,
  input  logic [31:0] m1_address_i,
  input  logic        m1_read_i,
  input  logic        m1_write_i,
  input  logic [31:0] m1_writedata_i,
  input  logic [3:0]  m1_byteenable_i,
  output logic        m1_waitrequest_o,
  output logic [31:0] m1_readdata_o,
  output logic [31:0] s_address_o,
  output logic        s_read_o,
  output logic        s_write_o,
  output logic [31:0] s_writedata_o,
  output logic [3:0]  s_byteenable_o,
  input  logic        s_waitrequest_i,
  input  logic [31:0] s_readdata_i,
  output logic [1:0]  grant_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCmd    = 2'd1;
  localparam logic [1:0] StRdWait = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  localparam logic [3:0] CntLoad = 4'(READ_LATENCY);

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req0, req1;
  logic [1:0]  winner;
  logic        complete;

  logic [31:0] g_address, g_writedata;
  logic [3:0]  g_byteenable;
  logic        g_read, g_write;

  assign req0 = m0_read_i | m0_write_i;
  assign req1 = m1_read_i | m1_write_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_grant_q, last_grant_d;

  // Tie goes to whichever master did not complete most recently.
  always_comb begin
    if (req0 && req1) begin
      winner = last_grant_q[0] ? 2'b10 : 2'b01;
    end else begin
      winner = req0 ? 2'b01 : 2'b10;
    end
  end

  assign last_grant_d = complete ? grant_q : last_grant_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= 2'b10;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign winner = req0 ? 2'b01 : 2'b10;
`endif

  // Live signals of the owning master; only forwarded to the slave in StCmd.
  always_comb begin
    if (grant_q[1]) begin
      g_address    = m1_address_i;
      g_read       = m1_read_i;
      g_write      = m1_write_i;
      g_writedata  = m1_writedata_i;
      g_byteenable = m1_byteenable_i;
    end else begin
      g_address    = m0_address_i;
      g_read       = m0_read_i;
      g_write      = m0_write_i;
      g_writedata  = m0_writedata_i;
      g_byteenable = m0_byteenable_i;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    rdata_d        = rdata_q;
    complete       = 1'b0;
    s_address_o    = '0;
    s_read_o       = 1'b0;
    s_write_o      = 1'b0;
    s_writedata_o  = '0;
    s_byteenable_o = '0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          grant_d = winner;
          state_d = StCmd;
        end
      end
      StCmd: begin
        s_address_o    = g_address;
        s_read_o       = g_read;
        s_write_o      = g_write;
        s_writedata_o  = g_writedata;
        s_byteenable_o = g_byteenable;
        if (!g_read && !g_write) begin
          // Owner withdrew its request: abandon without a completion.
          state_d = StIdle;
          grant_d = 2'b00;
        end else if (!s_waitrequest_i) begin
          if (g_write) begin
            complete = 1'b1;
            state_d  = StIdle;
            grant_d  = 2'b00;
          end else begin
            cnt_d   = CntLoad;
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          rdata_d = s_readdata_i;
          state_d = StResp;
        end
      end
      StResp: begin
        complete = 1'b1;
        state_d  = StIdle;
        grant_d  = 2'b00;
      end
      default: begin
        state_d = StIdle;
        grant_d = 2'b00;
      end
    endcase
  end

  assign m0_waitrequest_o = ~(complete & grant_q[0]);
  assign m1_waitrequest_o = ~(complete & grant_q[1]);
  assign m0_readdata_o    = rdata_q;
  assign m1_readdata_o    = rdata_q;
  assign grant_o          = grant_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: instance a uses READ_LATENCY=1,
// instance b uses READ_LATENCY=3. Both share master stimulus and slave stall.
module tb_mips_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_rd, m0_wr, m1_rd, m1_wr, s_wait;
  logic [3:0]  m0_be, m1_be;

  logic        a_m0_wait, a_m1_wait, a_s_rd, a_s_wr;
  logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata, a_s_rdata, a_raddr;
  logic [3:0]  a_s_be, a_cd;
  logic [1:0]  a_grant;

  logic        b_m0_wait, b_m1_wait, b_s_rd, b_s_wr;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata, b_s_rdata, b_raddr;
  logic [3:0]  b_s_be, b_cd;
  logic [1:0]  b_grant;

  int errors = 0;
  int checks = 0;

  mips_bus_arbiter #(.READ_LATENCY(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_address_i(m0_addr), .m0_read_i(m0_rd), .m0_write_i(m0_wr),
    .m0_writedata_i(m0_wdata), .m0_byteenable_i(m0_be),
    .m0_waitrequest_o(a_m0_wait), .m0_readdata_o(a_m0_rdata),
    .m1_address_i(m1_addr), .m1_read_i(m1_rd), .m1_write_i(m1_wr),
    .m1_writedata_i(m1_wdata), .m1_byteenable_i(m1_be),
    .m1_waitrequest_o(a_m1_wait), .m1_readdata_o(a_m1_rdata),
    .s_address_o(a_s_addr), .s_read_o(a_s_rd), .s_write_o(a_s_wr),
    .s_writedata_o(a_s_wdata), .s_byteenable_o(a_s_be),
    .s_waitrequest_i(s_wait), .s_readdata_i(a_s_rdata), .grant_o(a_grant)
  );

  mips_bus_arbiter #(.READ_LATENCY(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_address_i(m0_addr), .m0_read_i(m0_rd), .m0_write_i(m0_wr),
    .m0_writedata_i(m0_wdata), .m0_byteenable_i(m0_be),
    .m0_waitrequest_o(b_m0_wait), .m0_readdata_o(b_m0_rdata),
    .m1_address_i(m1_addr), .m1_read_i(m1_rd), .m1_write_i(m1_wr),
    .m1_writedata_i(m1_wdata), .m1_byteenable_i(m1_be),
    .m1_waitrequest_o(b_m1_wait), .m1_readdata_o(b_m1_rdata),
    .s_address_o(b_s_addr), .s_read_o(b_s_rd), .s_write_o(b_s_wr),
    .s_writedata_o(b_s_wdata), .s_byteenable_o(b_s_be),
    .s_waitrequest_i(s_wait), .s_readdata_i(b_s_rdata), .grant_o(b_grant)
  );

  // Slave memory contents: boot vector word, otherwise address-derived.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h3C08_BFC0 : (a ^ 32'h1234_5678);
  endfunction

  // Slave models: data valid exactly LATENCY cycles after acceptance, junk otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_cd <= 4'd0; a_raddr <= 32'd0; b_cd <= 4'd0; b_raddr <= 32'd0;
    end else begin
      if (a_s_rd && !s_wait) begin a_cd <= 4'd1; a_raddr <= a_s_addr; end
      else if (a_cd != 4'd0) a_cd <= a_cd - 4'd1;
      if (b_s_rd && !s_wait) begin b_cd <= 4'd3; b_raddr <= b_s_addr; end
      else if (b_cd != 4'd0) b_cd <= b_cd - 4'd1;
    end
  end
  assign a_s_rdata = (a_cd == 4'd1) ? mem(a_raddr) : 32'hDEAD_BEEF;
  assign b_s_rdata = (b_cd == 4'd1) ? mem(b_raddr) : 32'hDEAD_BEEF;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat (6) next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {m0_rd, m0_wr, m1_rd, m1_wr, s_wait} = '0;
    {m0_addr, m1_addr, m0_wdata, m1_wdata} = '0;
    {m0_be, m1_be} = '0;
    repeat (3) next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({a_s_rd, a_s_wr, a_grant, a_m0_wait, a_m1_wait} !== 6'b00_00_11) begin
        errors++;
        $display("FAIL reset_idle c%0d: got %b expected 000011", c,
                 {a_s_rd, a_s_wr, a_grant, a_m0_wait, a_m1_wait});
      end
      next_cycle();
    end
    checks++;
    if (a_m0_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 00000000", a_m0_rdata);
    end
  endtask

  task automatic test_m1_read();
    logic [4:0] exp;
    m1_addr = 32'hBFC0_0000; m1_rd = 1'b1; s_wait = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      exp = {(c == 1), (c >= 1 && c <= 3) ? 2'b10 : 2'b00, 1'b1, (c != 3)};
      checks++;
      if ({a_s_rd, a_grant, a_m0_wait, a_m1_wait} !== exp) begin
        errors++;
        $display("FAIL m1_read c%0d: got %b expected %b", c,
                 {a_s_rd, a_grant, a_m0_wait, a_m1_wait}, exp);
      end
      if (c == 1) begin
        checks++;
        if (a_s_addr !== 32'hBFC0_0000) begin
          errors++;
          $display("FAIL m1_read_addr: got %h expected bfc00000", a_s_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (a_m1_rdata !== 32'h3C08_BFC0) begin
          errors++;
          $display("FAIL m1_read_data: got %h expected 3c08bfc0", a_m1_rdata);
        end
      end
      next_cycle();
      if (c == 3) m1_rd = 1'b0;
    end
  endtask

  task automatic test_write_stall();
    logic [4:0] exp;
    m0_addr = 32'hBFC0_0030; m0_wdata = 32'h0000_FF00; m0_be = 4'b1111; m0_wr = 1'b1;
    for (int c = 0; c < 6; c++) begin
      s_wait = (c >= 1 && c <= 3);
      @(negedge clk);
      exp = {(c >= 1 && c <= 4), (c >= 1 && c <= 4) ? 2'b01 : 2'b00, (c != 4), 1'b1};
      checks++;
      if ({a_s_wr, a_grant, a_m0_wait, a_m1_wait} !== exp) begin
        errors++;
        $display("FAIL write_stall c%0d: got %b expected %b", c,
                 {a_s_wr, a_grant, a_m0_wait, a_m1_wait}, exp);
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if ({a_s_addr, a_s_wdata, a_s_be} !== {32'hBFC0_0030, 32'h0000_FF00, 4'hF}) begin
          errors++;
          $display("FAIL write_payload c%0d: got %h %h %h expected bfc00030 0000ff00 f",
                   c, a_s_addr, a_s_wdata, a_s_be);
        end
      end
      if (c == 5) begin
        checks++;
        if (a_m0_rdata !== 32'h3C08_BFC0) begin
          errors++;
          $display("FAIL write_keeps_rdata: got %h expected 3c08bfc0", a_m0_rdata);
        end
      end
      next_cycle();
      if (c == 4) m0_wr = 1'b0;
    end
    s_wait = 1'b0;
  endtask

  task automatic test_arbitration();
    logic [4:0] exp;
    logic [1:0] exp_tie2;
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200; m0_rd = 1'b1; m1_rd = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp[4:3] = (c >= 1 && c <= 3) ? 2'b01 : (c >= 5 && c <= 7) ? 2'b10 : 2'b00;
      exp[2:0] = {(c != 3), (c != 7), (c == 1 || c == 5)};
      checks++;
      if ({a_grant, a_m0_wait, a_m1_wait, a_s_rd} !== exp) begin
        errors++;
        $display("FAIL arb_tie c%0d: got %b expected %b", c,
                 {a_grant, a_m0_wait, a_m1_wait, a_s_rd}, exp);
      end
      if (c == 3) begin
        checks++;
        if (a_m0_rdata !== 32'h1234_5778) begin
          errors++;
          $display("FAIL arb_m0_data: got %h expected 12345778", a_m0_rdata);
        end
      end
      if (c == 5) begin
        checks++;
        if (a_s_addr !== 32'h0000_0200) begin
          errors++;
          $display("FAIL arb_m1_addr: got %h expected 00000200", a_s_addr);
        end
      end
      if (c == 7) begin
        checks++;
        if (a_m1_rdata !== 32'h1234_5478) begin
          errors++;
          $display("FAIL arb_m1_data: got %h expected 12345478", a_m1_rdata);
        end
      end
      next_cycle();
      if (c == 3) m0_rd = 1'b0;
      if (c == 7) m1_rd = 1'b0;
    end
    gap();
    // Second phase: both keep requesting; re-arbitration after m0's completion.
`ifdef ARB_ROUND_ROBIN_EN
    exp_tie2 = 2'b10;
`else
    exp_tie2 = 2'b01;
`endif
    m0_rd = 1'b1; m1_rd = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (a_grant !== 2'b01) begin
          errors++;
          $display("FAIL tie2_first: got %b expected 01", a_grant);
        end
      end
      if (c == 5) begin
        checks++;
        if (a_grant !== exp_tie2) begin
          errors++;
          $display("FAIL tie2_second: got %b expected %b", a_grant, exp_tie2);
        end
      end
      if (c == 6) begin
        checks++;
        if ({a_grant, a_m0_wait, a_m1_wait} !== 4'b00_11) begin
          errors++;
          $display("FAIL drop_no_completion: got %b expected 0011",
                   {a_grant, a_m0_wait, a_m1_wait});
        end
      end
      next_cycle();
      if (c == 4) begin m0_rd = 1'b0; m1_rd = 1'b0; end
    end
  endtask

  task automatic test_reset_midflight();
    m0_addr = 32'h0000_0300; m0_rd = 1'b1;
    repeat (2) next_cycle();
    // Now in the RDWAIT cycle of instance a.
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_s_rd, a_grant, a_m0_wait, a_m0_rdata} !== {1'b0, 2'b00, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL reset_midflight: got %b %b %b %h expected 0 00 1 00000000",
               a_s_rd, a_grant, a_m0_wait, a_m0_rdata);
    end
    m0_rd = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({a_grant, a_m0_wait, a_m1_wait} !== 4'b00_11) begin
        errors++;
        $display("FAIL reset_hold c%0d: got %b expected 0011", c,
                 {a_grant, a_m0_wait, a_m1_wait});
      end
    end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    m0_rd = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (a_m0_wait !== (c != 3)) begin
        errors++;
        $display("FAIL reread_wait c%0d: got %b expected %b", c, a_m0_wait, (c != 3));
      end
      if (c == 3) begin
        checks++;
        if (a_m0_rdata !== 32'h1234_5578) begin
          errors++;
          $display("FAIL reread_data: got %h expected 12345578", a_m0_rdata);
        end
      end
      next_cycle();
      if (c == 3) m0_rd = 1'b0;
    end
  endtask

  task automatic test_latency3();
    m1_addr = 32'hBFC0_0000; m1_rd = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if ({b_m1_wait, b_m0_wait} !== {(c != 5), 1'b1}) begin
        errors++;
        $display("FAIL lat3_wait c%0d: got %b expected %b", c,
                 {b_m1_wait, b_m0_wait}, {(c != 5), 1'b1});
      end
      if (c == 5) begin
        checks++;
        if ({b_m1_rdata, b_grant} !== {32'h3C08_BFC0, 2'b10}) begin
          errors++;
          $display("FAIL lat3_data: got %h %b expected 3c08bfc0 10", b_m1_rdata, b_grant);
        end
      end
      next_cycle();
      if (c == 5) m1_rd = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_m1_read();
    gap();
    test_write_stall();
    gap();
    test_arbitration();
    gap();
    test_reset_midflight();
    gap();
    test_latency3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
Two-master, one-slave arbiter for the mips_cpu_bus memory interface: address, read, write, waitrequest, writedata, byteenable, readdata.
- Shares one memory slave between master 0 (data port) and master 1 (instruction fetch).
- Sequences each transaction through slave waitrequest stalls and a fixed slave read latency.
- Returns one completion per transaction to the owning master by deasserting that master's waitrequest.

Parameters:
READ_LATENCY, 1, cycles from slave read acceptance (s_read=1, s_waitrequest=0) to valid s_readdata; legal range 1..15.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
m0_address / m1_address  in  32  master byte address
m0_read / m1_read  in  1  master read request
m0_write / m1_write  in  1  master write request
m0_writedata / m1_writedata  in  32  master write data
m0_byteenable / m1_byteenable  in  4  master byte enables
m0_waitrequest / m1_waitrequest  out  1  stall to master; low for exactly the completion cycle
m0_readdata / m1_readdata  out  32  read data; valid while own waitrequest=0 after a read
s_address  out  32  slave address
s_read  out  1  slave read strobe
s_write  out  1  slave write strobe
s_writedata  out  32  slave write data
s_byteenable  out  4  slave byte enables
s_waitrequest  in  1  slave stall
s_readdata  in  32  slave read data
grant  out  2  one-hot current owner {m1,m0}; 00 when no owner

Behaviour:
- Request: reqN = mN_read | mN_write. Read and write both high on one master is illegal; the arbiter forwards the signals unchecked.
- Reset (reset=0, asynchronous):
  - state=IDLE, grant=00, rdata_q=0, latency counter=0.
  - s_read=s_write=0; s_address, s_writedata, s_byteenable=0.
  - m0_waitrequest=m1_waitrequest=1.
  - Strobes drop immediately, including mid-transaction; any in-flight transaction is abandoned with no completion.
- Default outputs: mN_waitrequest=1 in every cycle except the completion cycle of the granted master. m0_readdata=m1_readdata=rdata_q.
- States:
  - IDLE: slave strobes 0, grant=00.
    - If any reqN: register the winner into grant and go to CMD. One cycle of arbitration latency.
    - Winner is fixed priority, m0 over m1; starvation of m1 is accepted.
  - CMD: slave outputs combinationally muxed from the granted master's live signals.
    - s_waitrequest=1: stay in CMD.
    - s_waitrequest=0 on a write: granted mN_waitrequest=0 in this same cycle, then go to IDLE.
    - s_waitrequest=0 on a read: load counter=READ_LATENCY, go to RDWAIT.
    - Granted master drops both read and write: go to IDLE, no completion.
  - RDWAIT: slave strobes 0, counter decrements each cycle. In the cycle counter==1, capture s_readdata into rdata_q and go to RESP.
  - RESP: granted mN_waitrequest=0 for one cycle with mN_readdata=rdata_q, then go to IDLE.
    - No back-to-back issue; the next request is re-arbitrated in IDLE.
- Timing, request first seen in IDLE at cycle 0, zero slave stalls:
  - Write completes in cycle 1.
  - Read completes in cycle 2+READ_LATENCY.
  - Each slave stall cycle adds one cycle.
- rdata_q holds its value between reads. Writes never modify it.
- The non-granted master sees waitrequest=1 throughout, and its signals never reach the slave.

Optional Feature:
ARB_ROUND_ROBIN_EN:
- Defined:
  - A last_grant register, reset to m1, is updated on every completion.
  - When both masters request in IDLE, the master not in last_grant wins.
  - A single requester always wins.
- Undefined: fixed priority, m0 over m1. No last_grant register exists.

Test Plan:
1. Release reset with both masters idle for 5 cycles -> s_read=s_write=0, grant=00, m0_waitrequest=m1_waitrequest=1 throughout.
2. m1 read of 0xBFC00000; slave model (READ_LATENCY=1) returns 0x3C08BFC0 one cycle after acceptance -> s_read=1 in cycle 1 only, grant=10, m1_waitrequest=0 in cycle 3 only with m1_readdata=0x3C08BFC0.
3. m0 write of 0x0000FF00 to 0xBFC00030 with byteenable 1111; slave holds s_waitrequest=1 for 3 cycles -> s_write=1 for 4 cycles with s_writedata=0x0000FF00, m0_waitrequest=0 only in the 4th CMD cycle.
4. m0 and m1 reads asserted in the same cycle -> m0 served first (grant=01), m1 granted in the IDLE after m0's RESP. With ARB_ROUND_ROBIN_EN, a second simultaneous tie is granted to m1.
5. Assert reset during RDWAIT of an m0 read -> s_read=0, grant=00, m0_waitrequest=1 immediately; after release, repeat the read -> correct data, no stale completion.
6. READ_LATENCY=3, m1 read with no stalls -> m1_waitrequest=0 in cycle 5 only, with correct m1_readdata.
